// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
// Run/step controller for the CPU core. Conditions the four raw active-low
// board buttons into debounced levels and one-cycle press pulses, then turns
// those into a one-cycle clock enable (cpu_en). The enable comes either from
// single-step presses while paused or from a free-running period counter
// at one of four rates. Everything downstream runs on the one system clock
// and is qualified by cpu_en.
//
// Button map: [0] run/pause toggle, [1] single step, [2] rate cycle,
// [3] spare (exported only).
//
// Run period is P = 2^(RATE_LOG2_MAX - 2*rate_idx) cycles.

module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RATE_LOG2_MAX   = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_n,
  output logic        cpu_en,
  output logic        running,
  output logic [1:0]  rate_idx,
  output logic [3:0]  btn_db,
  output logic [3:0]  btn_press,
  output logic [15:0] step_count
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  // Rate counter must hold up to 2^RATE_LOG2_MAX - 1 (slowest rate).
  localparam int CNT_W = RATE_LOG2_MAX;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // Input conditioning
  logic [3:0]      sync1_r;
  logic [3:0]      sync2_r;
  logic [3:0]      db_r;
  logic [3:0]      db_d_r;
  logic [3:0]      press_r;
  logic [DB_W-1:0] db_cnt_r [4];

  // Run/step control
  state_t          state_r;
  logic            running_r;
  logic [1:0]      rate_idx_r;
  logic [CNT_W-1:0] rate_cnt_r;
  logic            cpu_en_r;
  logic [15:0]     step_count_r;

  logic [CNT_W-1:0] period_m1_s;
  logic            at_last_s;

  // Two-flop synchronizer on the inverted (active-high) button levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= ~btn_n;
      sync2_r <= sync1_r;
    end
  end

  // Per-button debounce: accept a new level only after DEBOUNCE_CYCLES
  // consecutive differing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= DB_ZERO;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= DB_ZERO;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_r[i]     <= sync2_r[i];
          db_cnt_r[i] <= DB_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Rising-edge detect on the debounced levels; releases give no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_d_r  <= 4'b0000;
      press_r <= 4'b0000;
    end else begin
      db_d_r  <= db_r;
      press_r <= db_r & ~db_d_r;
    end
  end

  // Terminal count for the current rate: all-ones shifted down by 2*rate_idx.
  always_comb begin
    period_m1_s = CNT_ONES >> {rate_idx_r, 1'b0};
    at_last_s   = 1'b0;
    if (rate_cnt_r == period_m1_s) begin
      at_last_s = 1'b1;
    end else begin
      at_last_s = 1'b0;
    end
  end

  // Run/pause FSM with registered outputs, period counter and rate select.
  // A rate change or a pause press always wins over a pending run pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_PAUSED;
      running_r    <= 1'b0;
      rate_idx_r   <= 2'b00;
      rate_cnt_r   <= CNT_ZERO;
      cpu_en_r     <= 1'b0;
      step_count_r <= 16'h0000;
    end else begin
      step_count_r <= step_count_r + {15'b000000000000000, cpu_en_r};

      if (press_r[2]) begin
        rate_idx_r <= rate_idx_r + 2'b01;
      end else begin
        rate_idx_r <= rate_idx_r;
      end

      case (state_r)
        ST_PAUSED: begin
          rate_cnt_r <= CNT_ZERO;
          if (press_r[0]) begin
            // Run toggle beats a simultaneous step press.
            state_r   <= ST_RUNNING;
            running_r <= 1'b1;
            cpu_en_r  <= 1'b0;
          end else if (press_r[1]) begin
            state_r   <= ST_PAUSED;
            running_r <= 1'b0;
            cpu_en_r  <= 1'b1;
          end else begin
            state_r   <= ST_PAUSED;
            running_r <= 1'b0;
            cpu_en_r  <= 1'b0;
          end
        end
        ST_RUNNING: begin
          if (press_r[0]) begin
            state_r    <= ST_PAUSED;
            running_r  <= 1'b0;
            rate_cnt_r <= CNT_ZERO;
            cpu_en_r   <= 1'b0;
          end else if (press_r[2]) begin
            state_r    <= ST_RUNNING;
            running_r  <= 1'b1;
            rate_cnt_r <= CNT_ZERO;
            cpu_en_r   <= 1'b0;
          end else if (at_last_s) begin
            state_r    <= ST_RUNNING;
            running_r  <= 1'b1;
            rate_cnt_r <= CNT_ZERO;
            cpu_en_r   <= 1'b1;
          end else begin
            state_r    <= ST_RUNNING;
            running_r  <= 1'b1;
            rate_cnt_r <= rate_cnt_r + CNT_ONE;
            cpu_en_r   <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_PAUSED;
          running_r  <= 1'b0;
          rate_cnt_r <= CNT_ZERO;
          cpu_en_r   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_en     = cpu_en_r;
  assign running    = running_r;
  assign rate_idx   = rate_idx_r;
  assign btn_db     = db_r;
  assign btn_press  = press_r;
  assign step_count = step_count_r;

endmodule
